alu_result_display: RTL and testbench

//  Downstream stage of the 4-bit add/sub ALU experiment. Debounces two push buttons and latches the
//  ALU result F, flags {sign,zero,overflow,carryOut} and op M on a capture press. Renders the held

---
 rtl/alu_disp_pkg.sv | 39 +++
 rtl/pb_debounce.sv | 57 +++++
 rtl/alu_result_display.sv | 189 ++++++++++++++++++
 tb/tb_alu_result_display.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared display modes and seven-segment glyphs (active-low, bit0=a .. bit6=g, bit7=dp).
package alu_disp_pkg;

   typedef enum logic [1:0] {
      MODE_HEX  = 2'd0,
      MODE_UDEC = 2'd1,
      MODE_SDEC = 2'd2
   } disp_mode_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_MINUS = 8'hBF;
   localparam logic [7:0] SEG_A     = 8'h88;
   localparam logic [7:0] SEG_S     = 8'h92;

   function automatic logic [7:0] seg_hex(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'h0:    s = 8'hC0;
         4'h1:    s = 8'hF9;
         4'h2:    s = 8'hA4;
         4'h3:    s = 8'hB0;
         4'h4:    s = 8'h99;
         4'h5:    s = 8'h92;
         4'h6:    s = 8'h82;
         4'h7:    s = 8'hF8;
         4'h8:    s = 8'h80;
         4'h9:    s = 8'h90;
         4'hA:    s = 8'h88;
         4'hB:    s = 8'h83;
         4'hC:    s = 8'hC6;
         4'hD:    s = 8'hA1;
         4'hE:    s = 8'h86;
         4'hF:    s = 8'h8E;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/pb_debounce.sv
// Push-button debouncer: 2-FF synchronizer, N-cycle qualification, 1-cycle pulse on accepted press.
module pb_debounce #(
   parameter int CLK_HZ      = 10_000_000,
   parameter int DEBOUNCE_MS = 20
) (
   input  logic CLOCK,
   input  logic RST_N,
   input  logic btn_raw,
   output logic level,
   output logic rise_pulse
);
   localparam int N  = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;

   // Qualification: any cycle where the synced input agrees with the accepted level restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
            rise_d  = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchronizer and debounce state.
   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q  <= 2'b00;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/alu_result_display.sv
// Captures ALU result/flags/op on a button press and renders it on four digits in HEX/UDEC/SDEC.
// Optional build macro DISP_DP_FLAGS_EN: held flags shown on the decimal points.
module alu_result_display
   import alu_disp_pkg::*;
#(
   parameter int CLK_HZ      = 10_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int BLINK_HZ    = 2
) (
   input  logic       CLOCK,
   input  logic       RST_N,
   input  logic [3:0] F,
   input  logic [3:0] FLAGS,
   input  logic       M,
   input  logic       PB_CAPTURE,
   input  logic       PB_MODE,
   output logic [7:0] SD3,
   output logic [7:0] SD2,
   output logic [7:0] SD1,
   output logic [7:0] SD0,
   output logic [1:0] MODE,
   output logic       HELD_VALID
);
   localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic          cap_pulse_s, mode_pulse_s;
   logic          cap_level_unused_s, mode_level_unused_s;
   logic [3:0]    held_f_q, held_f_d;
   logic [3:0]    held_flags_q, held_flags_d;
   logic          held_m_q, held_m_d;
   logic          valid_q, valid_d;
   logic [1:0]    mode_q, mode_d, mode_next_s;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_ph_q, blink_ph_d;
   logic          blink_en_s;
   logic [3:0]    mag_s;
   logic [7:0]    sd3_q, sd2_q, sd1_q, sd0_q;
   logic [7:0]    sd3_d, sd2_d, sd1_d, sd0_d;

   pb_debounce #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_cap_db (
      .CLOCK      (CLOCK),
      .RST_N      (RST_N),
      .btn_raw    (PB_CAPTURE),
      .level      (cap_level_unused_s),
      .rise_pulse (cap_pulse_s)
   );

   pb_debounce #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_mode_db (
      .CLOCK      (CLOCK),
      .RST_N      (RST_N),
      .btn_raw    (PB_MODE),
      .level      (mode_level_unused_s),
      .rise_pulse (mode_pulse_s)
   );

   // Mode sequence; the unused encoding behaves like HEX.
   always_comb begin
      case (mode_q)
         MODE_HEX:  mode_next_s = MODE_UDEC;
         MODE_UDEC: mode_next_s = MODE_SDEC;
         MODE_SDEC: mode_next_s = MODE_HEX;
         default:   mode_next_s = MODE_UDEC;
      endcase
   end

   // Held data, mode and free-running blink phase.
   always_comb begin
      held_f_d     = held_f_q;
      held_flags_d = held_flags_q;
      held_m_d     = held_m_q;
      valid_d      = valid_q;
      if (cap_pulse_s) begin
         held_f_d     = F;
         held_flags_d = FLAGS;
         held_m_d     = M;
         valid_d      = 1'b1;
      end else begin
         valid_d = valid_q;
      end
      if (mode_pulse_s) begin
         mode_d = mode_next_s;
      end else begin
         mode_d = mode_q;
      end
      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_ph_d  = ~blink_ph_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
         blink_ph_d  = blink_ph_q;
      end
   end

   assign blink_en_s = ((mode_q == MODE_SDEC) && held_flags_q[1]) ||
                       ((mode_q == MODE_UDEC) && held_flags_q[0]);
   assign mag_s = (~held_f_q) + 4'd1;

   // Digit rendering from the held state; registered one cycle later.
   always_comb begin
      sd3_d = SEG_MINUS;
      sd2_d = SEG_MINUS;
      sd1_d = SEG_MINUS;
      sd0_d = SEG_MINUS;
      if (valid_q) begin
         sd3_d = held_m_q ? SEG_S : SEG_A;
         sd2_d = SEG_BLANK;
         sd1_d = SEG_BLANK;
         sd0_d = seg_hex(held_f_q);
         case (mode_q)
            MODE_UDEC: begin
               if (held_f_q > 4'd9) begin
                  sd1_d = seg_hex(4'd1);
                  sd0_d = seg_hex(held_f_q - 4'd10);
               end else begin
                  sd0_d = seg_hex(held_f_q);
               end
            end
            MODE_SDEC: begin
               if (held_f_q[3]) begin
                  sd2_d = SEG_MINUS;
                  sd0_d = seg_hex(mag_s);
               end else begin
                  sd0_d = seg_hex(held_f_q);
               end
            end
            default: sd0_d = seg_hex(held_f_q);
         endcase
         if (blink_ph_q && blink_en_s) begin
            sd2_d = SEG_BLANK;
            sd1_d = SEG_BLANK;
            sd0_d = SEG_BLANK;
         end else begin
            sd2_d = sd2_d;
         end
`ifdef DISP_DP_FLAGS_EN
         sd0_d[7] = ~held_flags_q[0];
         sd1_d[7] = ~held_flags_q[1];
         sd2_d[7] = ~held_flags_q[2];
         sd3_d[7] = ~held_flags_q[3];
`endif
      end else begin
         sd0_d = SEG_MINUS;
      end
   end

`ifndef DISP_DP_FLAGS_EN
   logic flags_unused_s;
   assign flags_unused_s = ^held_flags_q[3:2];
`endif

   // State and output registers.
   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         held_f_q     <= 4'd0;
         held_flags_q <= 4'd0;
         held_m_q     <= 1'b0;
         valid_q      <= 1'b0;
         mode_q       <= MODE_HEX;
         blink_cnt_q  <= '0;
         blink_ph_q   <= 1'b0;
         sd3_q        <= SEG_MINUS;
         sd2_q        <= SEG_MINUS;
         sd1_q        <= SEG_MINUS;
         sd0_q        <= SEG_MINUS;
      end else begin
         held_f_q     <= held_f_d;
         held_flags_q <= held_flags_d;
         held_m_q     <= held_m_d;
         valid_q      <= valid_d;
         mode_q       <= mode_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_ph_q   <= blink_ph_d;
         sd3_q        <= sd3_d;
         sd2_q        <= sd2_d;
         sd1_q        <= sd1_d;
         sd0_q        <= sd0_d;
      end
   end

   assign SD3        = sd3_q;
   assign SD2        = sd2_q;
   assign SD1        = sd1_q;
   assign SD0        = sd0_q;
   assign MODE       = mode_q;
   assign HELD_VALID = valid_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display: vector table, corner sequences and a random run
// compared every cycle against a behavioural model.
module tb_alu_result_display;
   localparam int N_DB = 4;
   localparam int HALF = 4;
   localparam logic [7:0] T_BLANK = 8'hFF;
   localparam logic [7:0] T_MINUS = 8'hBF;
   localparam logic [7:0] T_A     = 8'h88;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] f_in = 4'd0, flags_in = 4'd0;
   logic       m_in = 1'b0, pb_cap = 1'b0, pb_mode = 1'b0;
   logic [7:0] sd3, sd2, sd1, sd0;
   logic [1:0] mode_o;
   logic       valid_o;

   int n_vec = 0;
   int n_err = 0;

   alu_result_display #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .BLINK_HZ(125)) dut (
      .CLOCK(clk), .RST_N(rst_n), .F(f_in), .FLAGS(flags_in), .M(m_in),
      .PB_CAPTURE(pb_cap), .PB_MODE(pb_mode),
      .SD3(sd3), .SD2(sd2), .SD1(sd1), .SD0(sd0), .MODE(mode_o), .HELD_VALID(valid_o)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit         rdel [2][2];
   bit         win  [2][$];
   bit         lvl  [2];
   bit         pul  [2];
   bit         m_valid;
   bit         m_m;
   int         m_f;
   logic [3:0] m_flags;
   int         m_mode;
   int         m_k;
   logic [31:0] exp_sd;

   function automatic logic [7:0] glyph(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
         12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; 15: return 8'h8E;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] disp(input bit v, input bit m, input int f,
                                        input logic [3:0] fl, input int mode, input bit ph);
      logic [7:0] d [4];
      int sv;
      if (!v) return {T_MINUS, T_MINUS, T_MINUS, T_MINUS};
      d[3] = m ? glyph(5) : T_A;
      d[2] = T_BLANK;
      d[1] = T_BLANK;
      d[0] = glyph(f);
      if (mode == 1) begin
         if (f >= 10) d[1] = glyph(f / 10);
         d[0] = glyph(f % 10);
      end else if (mode == 2) begin
         sv = (f >= 8) ? f - 16 : f;
         if (sv < 0) begin
            d[2] = T_MINUS;
            sv = -sv;
         end
         d[0] = glyph(sv);
      end
      if (ph && ((mode == 2 && fl[1]) || (mode == 1 && fl[0]))) begin
         d[2] = T_BLANK; d[1] = T_BLANK; d[0] = T_BLANK;
      end
`ifdef DISP_DP_FLAGS_EN
      for (int i = 0; i < 4; i++) if (fl[i]) d[i][7] = 1'b0;
`endif
      return {d[3], d[2], d[1], d[0]};
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         rdel[b][0] = 1'b0; rdel[b][1] = 1'b0;
         win[b].delete();
         lvl[b] = 1'b0; pul[b] = 1'b0;
      end
      m_valid = 1'b0; m_m = 1'b0; m_f = 0; m_flags = 4'd0; m_mode = 0; m_k = 0;
      exp_sd = {T_MINUS, T_MINUS, T_MINUS, T_MINUS};
   endtask

   // A button level is accepted once the last N synchronized samples all disagree with it.
   task automatic deb_step(input int b, input bit raw, output bit pulse);
      bit cs, all_diff;
      cs = rdel[b][1];
      rdel[b][1] = rdel[b][0];
      rdel[b][0] = raw;
      win[b].push_back(cs);
      if (win[b].size() > N_DB) void'(win[b].pop_front());
      pulse = 1'b0;
      if (win[b].size() == N_DB) begin
         all_diff = 1'b1;
         for (int i = 0; i < win[b].size(); i++) if (win[b][i] == lvl[b]) all_diff = 1'b0;
         if (all_diff) begin
            lvl[b] = ~lvl[b];
            pulse = lvl[b];
         end
      end
   endtask

   task automatic model_edge();
      bit p0, p1;
      exp_sd = disp(m_valid, m_m, m_f, m_flags, m_mode, ((m_k / HALF) % 2) == 1);
      m_k++;
      if (pul[0]) begin
         m_f = int'(f_in); m_flags = flags_in; m_m = m_in; m_valid = 1'b1;
      end
      if (pul[1]) m_mode = (m_mode + 1) % 3;
      deb_step(0, pb_cap, p0);
      deb_step(1, pb_mode, p1);
      pul[0] = p0;
      pul[1] = p1;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic check_vec();
      logic [34:0] act, expv;
      act  = {sd3, sd2, sd1, sd0, mode_o, valid_o};
      expv = {exp_sd, 2'(m_mode), m_valid};
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL cycle_model: got %h expected %h (t=%0t)", act, expv, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_vec();
   endtask

   task automatic press_cap();
      pb_cap = 1'b1; repeat (7) cycle();
      pb_cap = 1'b0; repeat (7) cycle();
   endtask

   task automatic goto_mode(input int target);
      for (int i = 0; i < 3 && m_mode != target; i++) begin
         pb_mode = 1'b1; repeat (7) cycle();
         pb_mode = 1'b0; repeat (7) cycle();
      end
   endtask

   typedef struct {
      logic [3:0] f;
      logic       m;
      int         mode;
      logic [7:0] s3, s2, s1, s0;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int vis, blk, hold_c, hold_m;
      bit seen;
      logic [7:0] sd3_old;

      tbl[0]  = '{4'hB, 1'b0, 0, 8'h88, 8'hFF, 8'hFF, 8'h83};
      tbl[1]  = '{4'hB, 1'b0, 1, 8'h88, 8'hFF, 8'hF9, 8'hF9};
      tbl[2]  = '{4'hB, 1'b0, 2, 8'h88, 8'hBF, 8'hFF, 8'h92};
      tbl[3]  = '{4'h0, 1'b1, 0, 8'h92, 8'hFF, 8'hFF, 8'hC0};
      tbl[4]  = '{4'h9, 1'b1, 1, 8'h92, 8'hFF, 8'hFF, 8'h90};
      tbl[5]  = '{4'hF, 1'b0, 1, 8'h88, 8'hFF, 8'hF9, 8'h92};
      tbl[6]  = '{4'h7, 1'b0, 2, 8'h88, 8'hFF, 8'hFF, 8'hF8};
      tbl[7]  = '{4'h8, 1'b1, 2, 8'h92, 8'hBF, 8'hFF, 8'h80};
      tbl[8]  = '{4'hA, 1'b0, 0, 8'h88, 8'hFF, 8'hFF, 8'h88};
      tbl[9]  = '{4'h0, 1'b0, 2, 8'h88, 8'hFF, 8'hFF, 8'hC0};
      tbl[10] = '{4'hD, 1'b0, 0, 8'h88, 8'hFF, 8'hFF, 8'hA1};

      model_reset();
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();
      check("reset_sd", {sd3, sd2, sd1, sd0}, 32'hBFBFBFBF);
      check("reset_mode", 32'(mode_o), 32'd0);
      check("reset_valid", 32'(valid_o), 32'd0);

      // Table of captured values rendered in each mode.
      for (int i = 0; i < 11; i++) begin
         f_in = tbl[i].f; m_in = tbl[i].m; flags_in = 4'd0;
         press_cap();
         goto_mode(tbl[i].mode);
         repeat (2) cycle();
         check($sformatf("tbl%0d_sd", i), {sd3, sd2, sd1, sd0},
               {tbl[i].s3, tbl[i].s2, tbl[i].s1, tbl[i].s0});
         check($sformatf("tbl%0d_mode", i), 32'(mode_o), 32'(tbl[i].mode));
         check($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'd1);
      end

      // Bouncing capture button must not capture.
      f_in = 4'h3;
      for (int i = 0; i < 10; i++) begin
         pb_cap = ~pb_cap;
         repeat (2) cycle();
      end
      pb_cap = 1'b0;
      repeat (8) cycle();
      check("bounce_sd0", 32'(sd0), 32'(tbl[10].s0));

      // Overflow blink in SDEC; SD3 stays steady.
      f_in = 4'h8; flags_in = 4'b1010; m_in = 1'b0;
      press_cap();
      goto_mode(2);
      vis = 0; blk = 0; seen = 1'b0;
`ifdef DISP_DP_FLAGS_EN
      sd3_old = 8'h08;
`else
      sd3_old = 8'h88;
`endif
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (sd0 == 8'h80) vis++;
         else if (sd0 == 8'hFF) blk++;
         if (sd3 != sd3_old) seen = 1'b1;
      end
      check("blink_visible", 32'(vis), 32'd4);
      check("blink_blank", 32'(blk), 32'd4);
      check("blink_sd3_steady", 32'(seen), 32'd0);

      // Capture and mode qualify together.
      f_in = 4'h6; flags_in = 4'd0; m_in = 1'b1;
      pb_cap = 1'b1; pb_mode = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         if (mode_o == 2'd0) seen = 1'b1;
      end
      check("simul_mode_change", 32'(seen), 32'd1);
      check("simul_sd3_old", 32'(sd3), 32'(sd3_old));
      cycle();
      check("simul_sd_new", {sd3, sd0}, {8'h92, 8'h82});
      pb_cap = 1'b0; pb_mode = 1'b0;
      repeat (8) cycle();

`ifdef DISP_DP_FLAGS_EN
      f_in = 4'h0; flags_in = 4'b0101; m_in = 1'b0;
      press_cap();
      repeat (2) cycle();
      check("dp_bits", {28'd0, sd3[7], sd2[7], sd1[7], sd0[7]}, 32'b1010);
`endif

      // Reset asserted while the mode button is held.
      pb_mode = 1'b1;
      repeat (9) cycle();
      check("rstpress_mode1", 32'(mode_o), 32'd1);
      rst_n = 1'b0;
      model_reset();
      repeat (2) cycle();
      check("rstpress_in_reset", {30'd0, mode_o}, 32'd0);
      rst_n = 1'b1;
      repeat (3) cycle();
      check("rstpress_requal", 32'(mode_o), 32'd0);
      repeat (10) cycle();
      check("rstpress_one_pulse", 32'(mode_o), 32'd1);
      repeat (10) cycle();
      check("rstpress_no_repeat", 32'(mode_o), 32'd1);
      pb_mode = 1'b0;
      repeat (8) cycle();

      // Random stimulus against the model.
      hold_c = 0; hold_m = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold_c == 0) begin
            pb_cap = 1'($urandom);
            hold_c = int'($urandom_range(1, 9));
         end
         if (hold_m == 0) begin
            pb_mode = 1'($urandom);
            hold_m = int'($urandom_range(1, 9));
         end
         hold_c--; hold_m--;
         f_in = 4'($urandom); flags_in = 4'($urandom); m_in = 1'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
